imem_loader: RTL and testbench

Program loader that writes a byte stream into the instruction RAM through its byte-enable write port (`wea`/`addra`/`dina`). It is the writer side of that port and is used to download a new program image (e.g. from a UART or debug bridge) without re-synthesis. It holds the CPU in reset while loading, and can optionally read back and check every word it writes.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and writes them
// through the instruction RAM byte-enable port while holding the CPU in reset.
// Optional read-back check of every word: define IMEM_LOADER_VERIFY_EN.
module imem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_cnt,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [3:0]        wea,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  input  logic [31:0]       douta,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_VERIFY_EN
    S_RD,
    S_CMP,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              done_q, done_d;
  logic              advance;
`ifdef IMEM_LOADER_VERIFY_EN
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    idx_d   = idx_q;
    done_d  = done_q;
    advance = 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = word_cnt;
          idx_d   = '0;
          done_d  = 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
          err_d   = 1'b0;
`endif
          state_d = (word_cnt == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (in_valid) begin
          word_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
`ifdef IMEM_LOADER_VERIFY_EN
        state_d = S_RD;
`else
        advance = 1'b1;
`endif
      end
`ifdef IMEM_LOADER_VERIFY_EN
      S_RD: state_d = S_CMP;
      S_CMP: begin
        // On mismatch the address counter is frozen so addra reports the failing word.
        if (douta != word_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      addr_d  = addr_q + 1'b1;
      rem_d   = rem_q - 1'b1;
      state_d = (rem_q == ADDR_W'(1)) ? S_DONE : S_RECV;
    end

    // Abort overrides everything, including a simultaneous start; only the partial word is dropped.
    if (abort) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      rem_d   = rem_q;
      word_d  = word_q;
      idx_d   = '0;
      done_d  = done_q;
`ifdef IMEM_LOADER_VERIFY_EN
      err_d   = err_q;
`endif
    end else if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef IMEM_LOADER_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready = (state_q == S_RECV);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cpu_hold = busy;
  assign wea      = ((state_q == S_WRITE) && !abort) ? 4'hF : 4'h0;
  assign addra    = addr_q;
  assign dina     = word_q;
  assign done     = done_q;

`ifdef IMEM_LOADER_VERIFY_EN
  assign err = err_q;
`else
  logic unused_douta;
  assign unused_douta = ^douta;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus hand-written corner sequences,
// with a write scoreboard and a behavioural instruction RAM.
module tb_imem_loader;

`ifdef IMEM_LOADER_VERIFY_EN
  localparam int CPW = 7;
`else
  localparam int CPW = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] base_addr = '0;
  logic [11:0] word_cnt = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [3:0]  wea;
  logic [11:0] addra;
  logic [31:0] dina;
  logic [31:0] douta = '0;
  logic        cpu_hold, busy, done, err;

  int checks = 0;
  int errors = 0;

  imem_loader #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with 1-cycle read latency; optional corruption of bit 0 at word 5.
  logic [31:0] ram [4096];
  bit corrupt = 1'b0;
  always @(posedge clk) begin
    if (wea == 4'hF) ram[addra] <= dina;
    douta <= (corrupt && addra == 12'd5) ? (ram[addra] ^ 32'h1) : ram[addra];
  end

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write seen on the port must match the next expected entry.
  always @(negedge clk) begin
    if (wea != 4'h0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wea=%0h addra=%0h dina=%0h", wea, addra, dina);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_wea", {60'd0, wea}, 64'hF);
        check("wr_addr", {52'd0, addra}, {52'd0, e.addr});
        check("wr_data", {32'd0, dina}, {32'd0, e.data});
      end
    end
  end

  task automatic start_load(input logic [11:0] b, input logic [11:0] c);
    start = 1'b1; base_addr = b; word_cnt = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit mid, inout int cyc);
    int t;
    if (gap) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        if (mid) check("in_ready_gap", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1; cyc++;
      end
    end
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1; cyc++; t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1; in_data = b;
    @(posedge clk); #1; cyc++;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] a, input logic [31:0] w, input bit gap,
                           input bit push, inout int cyc);
    if (push) sb.push_back('{addr: a, data: w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap, k != 0, cyc);
  endtask

  task automatic wait_done(inout int cyc);
    int t;
    t = 0;
    while (!done && t < 100) begin
      @(posedge clk); #1; cyc++; t++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got 0 expected 1");
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_done, input logic [11:0] exp_addr);
    check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_hold"}, {63'd0, cpu_hold}, 64'd0);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_addra"}, {52'd0, addra}, {52'd0, exp_addr});
  endtask

  typedef struct {
    logic [11:0] base;
    logic [11:0] cnt;
    bit          gaps;
    bit          fixed;
    logic [11:0] exp_addra;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] fixed_w[2];

  initial begin
    int          cyc;
    logic [31:0] words[8];
    logic [11:0] a;

    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] words[8];
    logic [11:0] a;

    fixed_w[0] = 32'h10004693;
    fixed_w[1] = 32'h00001337;
    //          base     cnt    gaps  fixed exp_addra
    vecs[0] = '{12'h000, 12'd2, 1'b0, 1'b1, 12'h002};
    vecs[1] = '{12'h000, 12'd2, 1'b1, 1'b1, 12'h002};
    vecs[2] = '{12'h123, 12'd0, 1'b0, 1'b0, 12'h123};
    vecs[3] = '{12'hFFF, 12'd2, 1'b0, 1'b0, 12'h001};
    vecs[4] = '{12'h010, 12'd5, 1'b1, 1'b0, 12'h015};
    vecs[5] = '{12'h7FE, 12'd3, 1'b0, 1'b0, 12'h801};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_wea", {60'd0, wea}, 64'd0);
    check("rst_addra", {52'd0, addra}, 64'd0);
    check("rst_dina", {32'd0, dina}, 64'd0);
    check("rst_hold", {63'd0, cpu_hold}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      start_load(vecs[i].base, vecs[i].cnt);
      cyc = 0;
      check("start_busy", {63'd0, busy}, {63'd0, vecs[i].cnt != 0});
      for (int k = 0; k < int'(vecs[i].cnt); k++) begin
        a = vecs[i].base + 12'(k);
        words[k] = vecs[i].fixed ? fixed_w[k] : $urandom;
        send_word(a, words[k], vecs[i].gaps, 1'b1, cyc);
      end
      wait_done(cyc);
      check_idle_outputs("vec", 1'b1, vecs[i].exp_addra);
      check("vec_err", {63'd0, err}, 64'd0);
      check("vec_sb_empty", 64'(sb.size()), 64'd0);
      if (!vecs[i].gaps) check("vec_cycles", 64'(cyc), 64'(int'(vecs[i].cnt) * CPW));
      for (int k = 0; k < int'(vecs[i].cnt); k++) begin
        a = vecs[i].base + 12'(k);
        check("vec_ram", {32'd0, ram[a]}, {32'd0, words[k]});
      end
    end

    // Abort after two bytes, with a simultaneous start that must lose.
    start_load(12'h020, 12'd2);
    cyc = 0;
    send_byte(8'hAA, 1'b0, 1'b0, cyc);
    send_byte(8'hBB, 1'b0, 1'b1, cyc);
    abort = 1'b1; start = 1'b1; base_addr = 12'h400; word_cnt = 12'd3;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check_idle_outputs("abort", 1'b0, 12'h020);
    @(posedge clk); #1;
    check("abort_still_idle", {63'd0, busy}, 64'd0);
    start_load(12'h030, 12'd1);
    cyc = 0;
    send_word(12'h030, 32'hCAFE0123, 1'b0, 1'b1, cyc);
    wait_done(cyc);
    check_idle_outputs("after_abort", 1'b1, 12'h031);
    check("after_abort_ram", {32'd0, ram[12'h030]}, 64'hCAFE0123);

    // Abort in the WRITE cycle suppresses the write.
    start_load(12'h040, 12'd1);
    cyc = 0;
    send_word(12'h040, 32'h55667788, 1'b0, 1'b0, cyc);
    abort = 1'b1;
    @(negedge clk);
    check("abort_write_wea", {60'd0, wea}, 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle_outputs("abort_write", 1'b0, 12'h040);

    // Reset during WRITE: the issued write lands, then every output returns to its reset value.
    start_load(12'h050, 12'd2);
    cyc = 0;
    send_word(12'h050, 32'h0BADF00D, 1'b0, 1'b1, cyc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw_in_ready", {63'd0, in_ready}, 64'd0);
    check("rstw_wea", {60'd0, wea}, 64'd0);
    check("rstw_addra", {52'd0, addra}, 64'd0);
    check("rstw_dina", {32'd0, dina}, 64'd0);
    check("rstw_hold", {63'd0, cpu_hold}, 64'd0);
    check("rstw_busy", {63'd0, busy}, 64'd0);
    check("rstw_done", {63'd0, done}, 64'd0);
    check("rstw_err", {63'd0, err}, 64'd0);
    check("rstw_ram", {32'd0, ram[12'h050]}, 64'h0BADF00D);

    // Start pulsed mid-load is ignored.
    start_load(12'h060, 12'd2);
    cyc = 0;
    sb.push_back('{addr: 12'h060, data: 32'h44332211});
    send_byte(8'h11, 1'b0, 1'b0, cyc);
    send_byte(8'h22, 1'b0, 1'b1, cyc);
    start = 1'b1; base_addr = 12'h300; word_cnt = 12'd9;
    send_byte(8'h33, 1'b0, 1'b1, cyc);
    start = 1'b0;
    send_byte(8'h44, 1'b0, 1'b1, cyc);
    send_word(12'h061, 32'h88776655, 1'b0, 1'b1, cyc);
    wait_done(cyc);
    check_idle_outputs("ign_start", 1'b1, 12'h062);
    check("ign_start_sb", 64'(sb.size()), 64'd0);

`ifdef IMEM_LOADER_VERIFY_EN
    // Read-back mismatch at word 5 stops the load there.
    corrupt = 1'b1;
    start_load(12'h003, 12'd4);
    cyc = 0;
    for (int k = 0; k < 3; k++) send_word(12'h003 + 12'(k), $urandom, 1'b0, 1'b1, cyc);
    wait_done(cyc);
    check("vfy_err", {63'd0, err}, 64'd1);
    check_idle_outputs("vfy", 1'b1, 12'h005);
    check("vfy_sb", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("vfy_err_sticky", {63'd0, err}, 64'd1);
    corrupt = 1'b0;
    start_load(12'h008, 12'd1);
    cyc = 0;
    check("vfy_err_cleared", {63'd0, err}, 64'd0);
    send_word(12'h008, 32'h13579BDF, 1'b0, 1'b1, cyc);
    wait_done(cyc);
    check("vfy_ok_err", {63'd0, err}, 64'd0);
    check("vfy_ok_cycles", 64'(cyc), 64'd7);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
